// File: rtl/pe_pkg.sv
// Shared types and helpers for the multiply-accumulate processing element family.
package pe_pkg;

   // Widest slot index any PE variant may use; narrower indices are zero-extended.
   localparam int IDX_MAX_W = 16;

   typedef struct packed {
      logic                 valid;
      logic [IDX_MAX_W-1:0] idx;
      logic                 first;
      logic                 last;
   } stage_t;

   function automatic int acc_width(input int data_w, input int guard_w);
      return 2 * data_w + guard_w;
   endfunction

   // Position of the half-LSB rounding bias; only meaningful when there are fraction bits.
   function automatic int bias_shift(input int frac_w);
      return (frac_w > 0) ? frac_w - 1 : 0;
   endfunction

endpackage

// File: rtl/pe_round_sat.sv
// Converts a wide accumulator to the output format: round half toward +inf, then clip.
module pe_round_sat
   import pe_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int ACC_W  = 40
) (
   input  logic signed [ACC_W-1:0]  acc,
   output logic signed [DATA_W-1:0] data,
   output logic                     sat
);

   // One extra bit so adding the bias can never wrap.
   localparam int SUM_W = ACC_W + 1;
   localparam logic signed [SUM_W-1:0] BIAS =
      (FRAC_W > 0) ? (SUM_W'(1) << bias_shift(FRAC_W)) : '0;

   logic signed [SUM_W-1:0]  sum;
   logic signed [SUM_W-1:0]  shifted;
   logic [SUM_W-DATA_W:0]    upper;

   always_comb begin
      // NOTE: every output gets a default first so no path through this block infers a latch.
      data    = '0;
      sat     = 1'b0;
      sum     = SUM_W'(acc) + BIAS;
      shifted = sum >>> FRAC_W;
      upper   = shifted[SUM_W-1:DATA_W-1];
      if (upper == '0 || upper == '1) begin
         data = shifted[DATA_W-1:0];
      end else begin
         sat  = 1'b1;
         data = shifted[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                 : {1'b0, {(DATA_W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/mac_pe.sv
// Pipelined multiply-accumulate PE with DEPTH indexed accumulator slots and a
// rounded, saturated result port; one operand beat per cycle under a global stall.
module mac_pe
   import pe_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int FRAC_W  = 8,
   parameter int DEPTH   = 16,
   parameter int IDX_W   = 4,
   parameter int GUARD_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_a,
   input  logic signed [DATA_W-1:0] in_b,
   input  logic [IDX_W-1:0]         in_idx,
   input  logic                     in_first,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic [IDX_W-1:0]         out_idx,
   output logic                     out_sat,
   output logic                     err,
   output logic                     busy
);

   localparam int ACC_W  = acc_width(DATA_W, GUARD_W);
   localparam int PROD_W = 2 * DATA_W;
   localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   stage_t                   s1, s2, s3;
   logic signed [DATA_W-1:0] s1_a, s1_b;
   logic signed [PROD_W-1:0] s2_prod, s3_prod;
   logic signed [ACC_W-1:0]  acc [DEPTH];

   logic                     en;
   logic                     in_range;
   logic                     wr;
   logic                     emit;
   logic [SLOT_W-1:0]        slot;
   logic signed [ACC_W-1:0]  acc_new;
   logic signed [DATA_W-1:0] rs_data;
   logic                     rs_sat;

   // The whole pipeline advances only when the output register can take a result.
   assign en       = !out_valid || out_ready;
   assign in_ready = en && !clr;
   assign busy     = s1.valid || s2.valid || s3.valid || out_valid;

   assign in_range = s3.idx < IDX_MAX_W'(DEPTH);
   assign slot     = s3.idx[SLOT_W-1:0];
   assign wr       = s3.valid && in_range;
   assign emit     = wr && s3.last;

   // Read and write of a slot both happen here, so back-to-back same-slot beats need no bypass.
   assign acc_new  = s3.first ? ACC_W'(s3_prod) : acc[slot] + ACC_W'(s3_prod);

   pe_round_sat #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
   ) u_round_sat (
      .acc  (acc_new),
      .data (rs_data),
      .sat  (rs_sat)
   );

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1        <= '0;
         s2        <= '0;
         s3        <= '0;
         s1_a      <= '0;
         s1_b      <= '0;
         s2_prod   <= '0;
         s3_prod   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         out_sat   <= 1'b0;
         err       <= 1'b0;
         // NOTE: the slot array is architecturally visible state, so it is reset like any register.
         for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
      end else if (clr) begin
         s1        <= '0;
         s2        <= '0;
         s3        <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
         for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
      end else if (en) begin
         s1      <= '{valid: in_valid, idx: IDX_MAX_W'(in_idx), first: in_first, last: in_last};
         s1_a    <= in_a;
         s1_b    <= in_b;
         s2      <= s1;
         s2_prod <= PROD_W'(s1_a) * PROD_W'(s1_b);
         s3      <= s2;
         s3_prod <= s2_prod;

         if (wr) acc[slot] <= acc_new;
         if (s3.valid && !in_range) err <= 1'b1;

         out_valid <= emit;
         if (emit) begin
            out_data <= rs_data;
            out_idx  <= s3.idx[IDX_W-1:0];
            out_sat  <= rs_sat;
         end
      end
   end

endmodule

// File: tb/tb_mac_pe.sv
// Self-checking bench for mac_pe: directed cases with literal results plus a
// randomized stream compared against a transaction-level accumulate model.
module tb_mac_pe;

   localparam int DATA_W  = 16;
   localparam int FRAC_W  = 8;
   localparam int DEPTH   = 4;
   localparam int IDX_W   = 4;
   localparam int GUARD_W = 8;
   localparam int ACC_W   = 2 * DATA_W + GUARD_W;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
      logic              sat;
   } res_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              clr = 1'b0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_a = '0;
   logic [DATA_W-1:0] in_b = '0;
   logic [IDX_W-1:0]  in_idx = '0;
   logic              in_first = 1'b0;
   logic              in_last = 1'b0;
   logic              out_ready = 1'b1;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [IDX_W-1:0]  out_idx;
   logic              out_sat;
   logic              err;
   logic              busy;

   mac_pe #(
      .DATA_W  (DATA_W),
      .FRAC_W  (FRAC_W),
      .DEPTH   (DEPTH),
      .IDX_W   (IDX_W),
      .GUARD_W (GUARD_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_idx    (in_idx),
      .in_first  (in_first),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_sat   (out_sat),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     passed = 0;
   longint m_acc [DEPTH];
   bit     m_err = 1'b0;
   res_t   exp_q[$];
   res_t   obs[$];
   res_t   e;
   bit     prev_hold = 1'b0;
   logic [IDX_W+DATA_W:0] prev_word = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
   endtask

   // Model: accumulate in plain 64-bit arithmetic, then reduce to ACC_W bits two's complement.
   function automatic longint wrap_acc(input longint x);
      longint t;
      t = x <<< (64 - ACC_W);
      return t >>> (64 - ACC_W);
   endfunction

   function automatic res_t round_sat(input int idx, input longint v);
      res_t   r;
      longint q;
      longint maxv;
      maxv  = (longint'(1) <<< (DATA_W - 1)) - 1;
      q     = (v + (longint'(1) <<< (FRAC_W - 1))) >>> FRAC_W;
      r.idx = IDX_W'(idx);
      if (q > maxv) begin
         r.data = DATA_W'(maxv);
         r.sat  = 1'b1;
      end else if (q < -maxv - 1) begin
         r.data = DATA_W'(-maxv - 1);
         r.sat  = 1'b1;
      end else begin
         r.data = DATA_W'(q);
         r.sat  = 1'b0;
      end
      return r;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < DEPTH; i++) m_acc[i] = 0;
      exp_q.delete();
      m_err = 1'b0;
   endfunction

   function automatic void model_accept(input logic [DATA_W-1:0] a, b, input int idx,
                                        input bit first, last);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      if (idx >= DEPTH) begin
         m_err = 1'b1;
      end else begin
         m_acc[idx] = wrap_acc(first ? p : m_acc[idx] + p);
         if (last) exp_q.push_back(round_sat(idx, m_acc[idx]));
      end
   endfunction

   // Single compare process: inputs change only just after posedge, so negedge sees settled values.
   always @(negedge clk) begin
      if (!rst) begin
         model_clear();
         prev_hold = 1'b0;
      end else begin
         check("in_ready_rule", in_ready, (!out_valid || out_ready) && !clr);
         if (prev_hold) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_word", {out_idx, out_data, out_sat}, prev_word);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", out_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("out_idx", out_idx, e.idx);
               check("out_data", out_data, e.data);
               check("out_sat", out_sat, e.sat);
               obs.push_back('{idx: out_idx, data: out_data, sat: out_sat});
            end
         end
         if (clr) model_clear();
         else if (in_valid && in_ready) model_accept(in_a, in_b, int'(in_idx), in_first, in_last);
         prev_hold = out_valid && !out_ready && !clr;
         prev_word = {out_idx, out_data, out_sat};
      end
   end

   // Presents one beat and returns just after the edge that accepted it.
   task automatic drive(input logic [DATA_W-1:0] a, b, input int idx, input bit first, last);
      bit accepted = 1'b0;
      in_a     = a;
      in_b     = b;
      in_idx   = IDX_W'(idx);
      in_first = first;
      in_last  = last;
      in_valid = 1'b1;
      for (int k = 0; k < 200 && !accepted; k++) begin
         @(negedge clk);
         accepted = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("accept", accepted, 1'b1);
   endtask

   task automatic wait_idle();
      bit idle = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 200 && !idle; k++) begin
         @(negedge clk);
         idle = !busy;
      end
      check("drain_idle", idle, 1'b1);
      check("queue_empty", exp_q.size(), 0);
      check("err_model", err, m_err);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 16'h0000);
      check("rst_out_idx", out_idx, 4'h0);
      check("rst_out_sat", out_sat, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_busy", busy, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1 check("rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // Single beat: latency and value.
      obs.delete();
      drive(16'h0100, 16'h0200, 0, 1'b1, 1'b1);
      check("lat_t0", out_valid, 1'b0);
      @(posedge clk); #1 check("lat_t1", out_valid, 1'b0);
      @(posedge clk); #1 check("lat_t2", out_valid, 1'b0);
      @(posedge clk); #1 check("lat_t3", out_valid, 1'b1);
      check("t1_data", out_data, 16'h0200);
      check("t1_idx", out_idx, 4'h0);
      check("t1_sat", out_sat, 1'b0);
      wait_idle();

      // Three-beat accumulation on slot 1.
      obs.delete();
      drive(16'h0100, 16'h0100, 1, 1'b1, 1'b0);
      drive(16'h0100, 16'h0080, 1, 1'b0, 1'b0);
      drive(16'h0100, 16'hFF00, 1, 1'b0, 1'b1);
      wait_idle();
      check("t2_count", obs.size(), 1);
      if (obs.size() == 1) check("t2_data", obs[0].data, 16'h0080);

      // Interleaved slots 0 and 2.
      obs.delete();
      drive(16'h0100, 16'h0100, 0, 1'b1, 1'b0);
      drive(16'h0100, 16'h0100, 2, 1'b1, 1'b0);
      drive(16'h0100, 16'h0100, 0, 1'b0, 1'b1);
      drive(16'h0100, 16'h0100, 2, 1'b0, 1'b1);
      wait_idle();
      check("t3_count", obs.size(), 2);
      if (obs.size() == 2) begin
         check("t3_idx0", obs[0].idx, 4'h0);
         check("t3_data0", obs[0].data, 16'h0200);
         check("t3_idx1", obs[1].idx, 4'h2);
         check("t3_data1", obs[1].data, 16'h0200);
      end

      // Saturation in both directions.
      obs.delete();
      drive(16'h7FFF, 16'h7FFF, 3, 1'b1, 1'b1);
      drive(16'h8000, 16'h7FFF, 3, 1'b1, 1'b1);
      wait_idle();
      check("t4_count", obs.size(), 2);
      if (obs.size() == 2) begin
         check("t4_pos", {obs[0].data, obs[0].sat}, {16'h7FFF, 1'b1});
         check("t4_neg", {obs[1].data, obs[1].sat}, {16'h8000, 1'b1});
      end

      // Backpressure: continuous last beats while the consumer stalls.
      obs.delete();
      out_ready = 1'b0;
      fork
         begin
            for (int k = 0; k < 6; k++) drive(16'h0100, DATA_W'((k + 1) * 256), k % DEPTH, 1'b1, 1'b1);
         end
         begin
            for (int c = 0; c < 50 && !out_valid; c++) @(posedge clk);
            #1;
            check("bp_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_idle();
      check("bp_count", obs.size(), 6);
      for (int k = 0; k < 6 && k < obs.size(); k++) begin
         check("bp_data", obs[k].data, DATA_W'((k + 1) * 256));
         check("bp_idx", obs[k].idx, IDX_W'(k % DEPTH));
      end

      // Out-of-range slot, then clear.
      obs.delete();
      drive(16'h0100, 16'h0100, 5, 1'b1, 1'b1);
      wait_idle();
      check("oor_err", err, 1'b1);
      check("oor_no_out", obs.size(), 0);
      clr = 1'b1;
      #1 check("clr_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1 clr = 1'b0;
      check("clr_err", err, 1'b0);
      drive(16'h0100, 16'h0100, 0, 1'b0, 1'b1);
      wait_idle();
      check("clr_count", obs.size(), 1);
      if (obs.size() == 1) check("clr_slot", obs[0].data, 16'h0100);

      // Reset in the middle of a stream.
      obs.delete();
      drive(16'h0100, 16'h0100, 2, 1'b1, 1'b1);
      drive(16'h0100, 16'h0100, 2, 1'b0, 1'b1);
      rst = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1 check("mid_rst_ready", in_ready, 1'b1);
      obs.delete();
      drive(16'h0100, 16'h0300, 2, 1'b0, 1'b1);
      wait_idle();
      check("mid_rst_count", obs.size(), 1);
      if (obs.size() == 1) check("mid_rst_slot", obs[0].data, 16'h0300);

      // Randomized stream with random consumer stalls and occasional clears.
      for (int c = 0; c < 800; c++) begin
         in_valid = ($urandom_range(0, 9) < 8);
         in_idx   = ($urandom_range(0, 15) == 0) ? IDX_W'(5) : IDX_W'($urandom_range(0, DEPTH - 1));
         in_first = ($urandom_range(0, 2) == 0);
         in_last  = ($urandom_range(0, 1) == 0);
         if ($urandom_range(0, 3) == 0) begin
            in_a = DATA_W'($urandom);
            in_b = DATA_W'($urandom);
         end else begin
            in_a = DATA_W'(int'($urandom_range(0, 2047)) - 1024);
            in_b = DATA_W'(int'($urandom_range(0, 2047)) - 1024);
         end
         out_ready = ($urandom_range(0, 9) < 7);
         clr       = ($urandom_range(0, 199) == 0);
         @(posedge clk);
         #1;
      end
      clr = 1'b0;
      wait_idle();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/mac_pe.md
Name: mac_pe

Overview:
Parametrised multiply-accumulate processing element: the next-generation replacement for the single-accumulator process unit in the DNN datapath. It accepts a stream of signed fixed-point (a, b, idx) operand pairs over a valid/ready handshake and accumulates each product into one of DEPTH per-neuron accumulator slots selected by idx. On a "last" beat it emits the rounded, saturated slot result over a second valid/ready handshake. It is fully pipelined (one beat per cycle), single-clock, and has no separate s_clk/m_clk.

Parameters:
DATA_W, 16, operand and output width (signed two's complement)
FRAC_W, 8, fractional bits of operands and output (Q(DATA_W-FRAC_W).FRAC_W); 0 <= FRAC_W < DATA_W
DEPTH, 16, number of accumulator slots
IDX_W, 4, index width; DEPTH <= 2**IDX_W
GUARD_W, 8, accumulator guard bits; ACC_W = 2*DATA_W + GUARD_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of all slots, pipeline and err
in_valid  in  1  operand beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_a  in  DATA_W  signed operand (activation)
in_b  in  DATA_W  signed operand (weight)
in_idx  in  IDX_W  accumulator slot (weight column index)
in_first  in  1  beat overwrites slot (acc = product) instead of adding
in_last  in  1  beat completes slot; produces an output
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_data  out  DATA_W  rounded, saturated result
out_idx  out  IDX_W  slot that produced out_data
out_sat  out  1  out_data was clipped
err  out  1  sticky: beat with in_idx >= DEPTH was seen
busy  out  1  any pipeline stage valid or out_valid high

Behaviour:
- Reset (rst=0, async): all slots 0, stage valids 0, out_valid=0, out_data=0, out_idx=0, out_sat=0, err=0, busy=0. in_ready=1 after reset release.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en && !clr. When en=0, every stage holds (global stall; no beat lost, no duplicate).
- S1 (accept): registers a, b, idx, first, last, valid.
- S2: signed product DATA_W x DATA_W -> 2*DATA_W, registered.
- S3: read slot idx combinationally; new = first ? sext(prod) : acc[idx] + sext(prod), modulo 2**ACC_W (wraps; no accumulator saturation). Write new to acc[idx]. Same-slot back-to-back beats need no forwarding, since read and write occur in the same stage.
- Output: if the S3 beat has last=1, the output register loads on the same edge as the write. out_valid rises 3 cycles after the accepting edge (accept at edge t, out_valid high after edge t+3). Output holds until handshake. A beat with last=0 never touches output.
- Round/sat: r = (new + (FRAC_W>0 ? 2**(FRAC_W-1) : 0)) >>> FRAC_W (arithmetic; round half toward +inf). Clip to [-2**(DATA_W-1), 2**(DATA_W-1)-1]; out_sat=1 iff clipped.
- Slot retained after last. A later first beat restarts it; a later non-first beat continues accumulating.
- in_idx >= DEPTH: beat passes the pipeline but is not written and produces no output even if last. err is set at S3 and sticky until clr/rst.
- clr: all slots, stage valids, out_valid and err cleared on that edge. in_ready=0 during clr. clr overrides in-flight beats (they are dropped).
- Simultaneous out handshake and new last reaching S3: allowed at full rate (en=1); output register reloads.
- rst mid-operation: everything cleared immediately, in-flight beats lost, no output emitted.

Decomposition:
- Package pe_pkg: ACC_W derivation function, round/saturate helper constants, pipeline stage record typedef (valid, idx, first, last).
- One natural sub-module: pe_round_sat (combinational ACC_W -> DATA_W round + clip + sat flag), reusable by future PE variants.

Test Plan:
- Params DATA_W=16, FRAC_W=8, DEPTH=4. a=0x0100, b=0x0200, idx=0, first=last=1 -> out_valid 3 cycles later, out_data=0x0200, out_idx=0, out_sat=0.
- Three beats idx=1 (first on beat 1, last on beat 3), a=0x0100 with b=0x0100, 0x0080, 0xFF00 -> single output out_data=0x0080.
- Interleaved idx 0/2 back-to-back, each 2 beats of 0x0100*0x0100 -> two outputs 0x0200, order idx0 then idx2, no slot crosstalk.
- Saturation: 0x7FFF*0x7FFF first/last -> out_data=0x7FFF, out_sat=1. 0x8000*0x7FFF -> 0x8000, out_sat=1.
- Backpressure: out_ready=0 for 5 cycles with continuous last beats -> in_ready falls, pipeline holds, and all results delivered in order once out_ready=1.
- idx=5 last beat -> no output, err=1. clr -> err=0, slots 0. rst asserted mid-stream -> out_valid=0 and busy=0 immediately.
